// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the adder controller: FSM encoding, register
// offsets and the bit positions of the CTRL and STATUS registers.
// Optional feature macro: ADDER_CTRL_TIMEOUT_EN (see adder_ctrl.sv).
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2,
        StClr  = 2'd3
    } state_e;

    // Register offsets
    localparam logic [2:0] AddrCtrl    = 3'd0;
    localparam logic [2:0] AddrStatus  = 3'd1;
    localparam logic [2:0] AddrFifoDin = 3'd2;
    localparam logic [2:0] AddrIntClr  = 3'd3;
    localparam logic [2:0] AddrTimeout = 3'd4;

    // CTRL bits (start/clear self-clear, irq_en is stored)
    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlClear = 1;
    localparam int unsigned CtrlIrqEn = 2;

    // INT_CLR bit
    localparam int unsigned IntClrBit = 0;

    // STATUS bits
    localparam int unsigned StatBusy       = 0;
    localparam int unsigned StatDone       = 1;
    localparam int unsigned StatFull       = 2;
    localparam int unsigned StatStartErr   = 3;
    localparam int unsigned StatPushErr    = 4;
    localparam int unsigned StatTimeoutErr = 5;
    localparam int unsigned StatCntLsb     = 8;

    // Sticky status flags plus the interrupt level
    typedef struct packed {
        logic done;
        logic start_err;
        logic push_err;
        logic timeout_err;
        logic irq;
    } flags_t;

endpackage

// File: rtl/adder_ctrl_ns.sv
// Combinational next-state, flag and result-counter logic for adder_ctrl.
// All state is held by the top level; this block only decides what changes.
module adder_ctrl_ns
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  state_e             state,
    input  flags_t             flags,
    input  logic [CNT_W-1:0]   result_cnt,
    input  logic               ctrl_start,
    input  logic               ctrl_clear,
    input  logic               int_clr,
    input  logic               push_wr,
    input  logic               fifo_full,
    input  logic [CNT_W-1:0]   fifo_data_count,
    input  logic               op_done,
    input  logic               rf_rise,
    input  logic               timeout_hit,
    input  logic               irq_en,
    output state_e             state_next,
    output flags_t             flags_next,
    output logic [CNT_W-1:0]   result_cnt_next,
    output logic               push_ok
);

    logic clear_taken;

    // Clear only acts in states that accept commands
    assign clear_taken = ctrl_clear && (state == StIdle || state == StRun);

    // Next state, flags and result count; clears are applied before sets so a
    // same-cycle event is never lost
    always_comb begin
        state_next      = state;
        flags_next      = flags;
        result_cnt_next = result_cnt;
        push_ok         = 1'b0;

        if (int_clr) begin
            flags_next = '0;
        end
        if (clear_taken) begin
            flags_next.start_err   = 1'b0;
            flags_next.push_err    = 1'b0;
            flags_next.timeout_err = 1'b0;
            flags_next.irq         = 1'b0;
        end

        // Operand pushes are only legal while the adder is not consuming the FIFO
        if (push_wr) begin
            if ((state == StIdle || state == StDone) && !fifo_full) begin
                push_ok = 1'b1;
            end else begin
                flags_next.push_err = 1'b1;
            end
        end

        unique case (state)
            StIdle: begin
                if (ctrl_clear) begin
                    state_next = StClr;
                end else if (ctrl_start) begin
                    if (fifo_data_count != '0) begin
                        state_next      = StRun;
                        result_cnt_next = '0;
                        flags_next.done = 1'b0;
                    end else begin
                        flags_next.start_err = 1'b1;
                    end
                end
            end
            StRun: begin
                if (rf_rise && result_cnt != '1) begin
                    result_cnt_next = result_cnt + CNT_W'(1);
                end
                if (ctrl_clear) begin
                    state_next = StClr;
                end else if (op_done) begin
                    state_next      = StDone;
                    flags_next.done = 1'b1;
                    if (irq_en) begin
                        flags_next.irq = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next             = StClr;
                    flags_next.timeout_err = 1'b1;
                    if (irq_en) begin
                        flags_next.irq = 1'b1;
                    end
                end
            end
            StDone: begin
                state_next = StIdle;
            end
            StClr: begin
                state_next      = StIdle;
                flags_next.done = 1'b0;
                result_cnt_next = '0;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/adder_ctrl.sv
// Bus-slave controller sequencing the FIFO-fed pairwise adder.
// Holds the FSM/flag flops, the register file and the read mux.
// Optional feature macro: ADDER_CTRL_TIMEOUT_EN adds the TIMEOUT_LIMIT
// register and a RUN watchdog; without it RUN ends only on op_done or clear.
module adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned     DW          = 32,
    parameter int unsigned     CNT_W       = 4,
    parameter int unsigned     TO_W        = 16,
    parameter logic [TO_W-1:0] TIMEOUT_DEF = 16'd1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_sel,
    input  logic             s_wr,
    input  logic [2:0]       s_addr,
    input  logic [DW-1:0]    s_din,
    output logic [DW-1:0]    s_dout,
    output logic             fifo_wr,
    output logic [DW-1:0]    fifo_din,
    input  logic             fifo_full,
    input  logic [CNT_W-1:0] fifo_data_count,
    output logic             op_start,
    output logic             op_clear,
    input  logic             op_done,
    input  logic             rf_we,
    output logic             irq
);

    state_e           state_q, state_d;
    flags_t           flags_q, flags_d;
    logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
    logic             irq_en_q;
    logic             rf_we_q;
    logic             fifo_wr_q;
    logic [DW-1:0]    fifo_din_q;
    logic [DW-1:0]    s_dout_q;
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    limit_rd;

    logic wr_en, rd_en;
    logic ctrl_wr, ctrl_start, ctrl_clear;
    logic int_clr, push_wr, push_ok;
    logic rf_rise, timeout_hit;

    assign wr_en      = s_sel && s_wr;
    assign rd_en      = s_sel && !s_wr;
    assign ctrl_wr    = wr_en && (s_addr == AddrCtrl);
    assign ctrl_start = ctrl_wr && s_din[CtrlStart];
    assign ctrl_clear = ctrl_wr && s_din[CtrlClear];
    assign int_clr    = wr_en && (s_addr == AddrIntClr) && s_din[IntClrBit];
    assign push_wr    = wr_en && (s_addr == AddrFifoDin);
    assign rf_rise    = rf_we && !rf_we_q;

`ifdef ADDER_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_limit_q;
    logic [TO_W-1:0] to_cnt_q;

    // Watchdog: counts RUN cycles, cleared in every other state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_limit_q <= TIMEOUT_DEF;
            to_cnt_q   <= '0;
        end else begin
            if (wr_en && s_addr == AddrTimeout) begin
                to_limit_q <= s_din[TO_W-1:0];
            end
            if (state_q == StRun) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign timeout_hit = (state_q == StRun) && (to_cnt_q == to_limit_q - TO_W'(1));
    assign limit_rd    = DW'(to_limit_q);
`else
    assign timeout_hit = 1'b0;
    assign limit_rd    = '0;
`endif

    adder_ctrl_ns #(
        .CNT_W(CNT_W)
    ) u_ns (
        .state           (state_q),
        .flags           (flags_q),
        .result_cnt      (result_cnt_q),
        .ctrl_start      (ctrl_start),
        .ctrl_clear      (ctrl_clear),
        .int_clr         (int_clr),
        .push_wr         (push_wr),
        .fifo_full       (fifo_full),
        .fifo_data_count (fifo_data_count),
        .op_done         (op_done),
        .rf_rise         (rf_rise),
        .timeout_hit     (timeout_hit),
        .irq_en          (irq_en_q),
        .state_next      (state_d),
        .flags_next      (flags_d),
        .result_cnt_next (result_cnt_d),
        .push_ok         (push_ok)
    );

    // FSM, flags, result counter and rf_we edge sampler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            flags_q      <= '0;
            result_cnt_q <= '0;
            rf_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            result_cnt_q <= result_cnt_d;
            rf_we_q      <= rf_we;
        end
    end

    // Stored interrupt enable, rewritten by every CTRL write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en_q <= s_din[CtrlIrqEn];
        end
    end

    // One-cycle FIFO push strobe with the operand registered alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
        end else begin
            fifo_wr_q <= push_ok;
            if (push_ok) begin
                fifo_din_q <= s_din;
            end
        end
    end

    // Read mux; unmapped and write-only offsets read as zero
    always_comb begin
        rd_data = '0;
        case (s_addr)
            AddrStatus: begin
                rd_data[StatBusy]                = (state_q == StRun);
                rd_data[StatDone]                = flags_q.done;
                rd_data[StatFull]                = fifo_full;
                rd_data[StatStartErr]            = flags_q.start_err;
                rd_data[StatPushErr]             = flags_q.push_err;
                rd_data[StatTimeoutErr]          = flags_q.timeout_err;
                rd_data[StatCntLsb +: CNT_W]     = result_cnt_q;
            end
            AddrTimeout: begin
                rd_data = limit_rd;
            end
            default: begin
                rd_data = '0;
            end
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_dout_q <= '0;
        end else if (rd_en) begin
            s_dout_q <= rd_data;
        end
    end

    // Outputs decode straight from flops so reset drops them immediately
    assign s_dout   = s_dout_q;
    assign fifo_wr  = fifo_wr_q;
    assign fifo_din = fifo_din_q;
    assign op_start = (state_q == StRun);
    assign op_clear = (state_q == StClr);
    assign irq      = flags_q.irq;

endmodule

// File: doc/adder_ctrl.md
Name: adder_ctrl

Overview:
Bus-slave controller that sequences the FIFO-fed pairwise adder.
- Host writes operands through a small register map; the controller pushes them into the operand FIFO.
- It drives op_start/op_clear, watches op_done and counts results written to the register file.
- It flags completion, errors and interrupts.
- It sits between the host bus and the adder/FIFO/RF cluster at top level.

Parameters:
DW, 32, operand/bus data width
CNT_W, 4, width of result counter and FIFO data count
TO_W, 16, width of timeout counter
TIMEOUT_DEF, 16'd1024, reset value of TIMEOUT_LIMIT register

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
s_sel  in  1  bus select
s_wr  in  1  1 = write, 0 = read
s_addr  in  3  register offset
s_din  in  DW  write data
s_dout  out  DW  read data, registered
fifo_wr  out  1  operand FIFO push strobe
fifo_din  out  DW  operand to FIFO
fifo_full  in  1  FIFO full
fifo_data_count  in  CNT_W  FIFO occupancy
op_start  out  1  adder start, level
op_clear  out  1  adder clear, 1-cycle pulse
op_done  in  1  adder finished
rf_we  in  1  adder RF write enable (monitored)
irq  out  1  interrupt, level

Behaviour:
- Reset: all outputs 0, state IDLE, flags 0, result_cnt 0, irq_en 0, TIMEOUT_LIMIT = TIMEOUT_DEF.
- Register map:
  - 0 CTRL (W): b0 start, b1 clear, b2 irq_en (sticky). Bits b0/b1 are self-clearing.
  - 1 STATUS (R): b0 busy, b1 done, b2 fifo_full, b3 start_err, b4 push_err, b5 timeout_err, b11:8 result_cnt.
  - 2 FIFO_DIN (W): push one operand.
  - 3 INT_CLR (W): b0 = 1 clears done, all err bits and irq.
  - 4 TIMEOUT_LIMIT (R/W).
  - Other offsets read 0; writes to them are ignored.
- Reads: s_dout updates the cycle after s_sel & !s_wr and holds otherwise.
- Push: a write to FIFO_DIN in IDLE or DONE with fifo_full = 0 gives fifo_wr = 1 and fifo_din = s_din in the next cycle (1-cycle pulse). Otherwise there is no push and push_err is set; this covers full, RUN and CLR.
- FSM states:
  - IDLE: CTRL.clear -> CLR. Else CTRL.start with fifo_data_count != 0 -> RUN; result_cnt cleared, done cleared. Else CTRL.start with count == 0 -> start_err set, stay IDLE.
  - RUN: op_start = 1, busy = 1, timeout counter increments each cycle. Transitions in priority order:
    - CTRL.clear -> CLR.
    - op_done = 1 -> DONE; done set, irq = irq_en.
    - counter == TIMEOUT_LIMIT-1 -> CLR; timeout_err set, irq = irq_en.
  - DONE: op_start = 0 (lets the adder leave its done state). Next cycle -> IDLE.
  - CLR: op_clear = 1 for exactly one cycle, timeout counter cleared -> IDLE. done and result_cnt are cleared, except that entry via timeout keeps timeout_err set.
- Clear and start in the same CTRL write: clear wins, start is dropped.
- result_cnt: increments on each rising edge of rf_we (rf_we=1 while the previous-cycle sample was 0) in RUN. It saturates at all-ones and does not wrap.
- irq: level signal. It stays high until INT_CLR or clear and is set only when irq_en = 1.
- Reset mid-RUN: immediate return to reset values. op_start drops asynchronously.

Optional Feature:
ADDER_CTRL_TIMEOUT_EN
- Defined: TIMEOUT_LIMIT register and timeout counter present; RUN exits to CLR on timeout as above.
- Undefined: no counter, offset 4 reads 0 and ignores writes, timeout_err is constant 0, RUN leaves only on op_done or clear.

Decomposition:
- Package adder_ctrl_pkg: state encodings IDLE/RUN/DONE/CLR (2-bit), register offsets, STATUS/CTRL bit positions.
- One sub-module, adder_ctrl_ns: combinational next-state and flag logic. The top level holds the flops, register file and read mux.

Test Plan:
1. Reset; read STATUS -> 0. Read TIMEOUT_LIMIT -> 1024.
2. Push 4 operands (1, 2, 3, 4); start with irq_en; adder model writes two results and asserts op_done -> op_start high until op_done, then DONE; STATUS done = 1, result_cnt = 2; irq = 1; INT_CLR -> irq = 0.
3. Start with fifo_data_count = 0 -> stays IDLE, op_start never high, STATUS start_err = 1.
4. Push with fifo_full = 1, and push during RUN -> no fifo_wr pulse, push_err = 1.
5. Write CTRL = 3'b011 while IDLE -> CLR for one cycle with op_clear pulse, no RUN.
6. With ADDER_CTRL_TIMEOUT_EN, TIMEOUT_LIMIT = 8, op_done held 0 -> after 8 RUN cycles: op_clear pulse, timeout_err = 1, state IDLE. Assert reset mid-RUN -> op_start = 0 immediately.
